moxie_wb_master: RTL and testbench

Parametrised Wishbone classic bus master shared by NCH Moxie client channels (instruction fetch, data load/store, later DMA/debug). It replaces the free-running per-bus strobe toggling with a real transfer engine. It provides:
- round-robin arbitration between channels;
- one registered single-beat transfer at a time;
- byte selects and read/write direction driven by the master;
- bus error and timeout reporting back to the requesting channel.

---
 rtl/moxie_wb_master.sv | 162 ++++++++++++++++
 tb/tb_moxie_wb_master.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/moxie_wb_master.sv
// moxie_wb_master: round-robin Wishbone classic master shared by NCH client
// channels. It issues one registered single-beat transfer at a time. The
// requesting channel gets a one-cycle done pulse, flagged as an error when
// the slave signals err or the slave stays silent for TIMEOUT cycles.
module moxie_wb_master #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int NCH     = 2,
  parameter int TIMEOUT = 255,
  localparam int SW     = DW / 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  // client channels
  input  logic [NCH-1:0]    req_i,
  input  logic [NCH-1:0]    we_i,
  input  logic [NCH*AW-1:0] adr_i,
  input  logic [NCH*DW-1:0] dat_i,
  input  logic [NCH*SW-1:0] sel_i,
  output logic [NCH-1:0]    gnt_o,
  output logic [NCH-1:0]    done_o,
  output logic [NCH-1:0]    err_o,
  output logic [DW-1:0]     rdat_o,
  // wishbone bus
  output logic [AW-1:0]     wb_adr_o,
  output logic [DW-1:0]     wb_dat_o,
  output logic [SW-1:0]     wb_sel_o,
  output logic              wb_we_o,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  input  logic [DW-1:0]     wb_dat_i,
  input  logic              wb_ack_i,
  input  logic              wb_err_i
);

  // Channel index width. The pick arithmetic below needs at least one bit,
  // so a single-channel build still gets a 1-bit index.
  localparam int LW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // A transfer times out on the silent cycle in which the counter would
  // reach TIMEOUT. The counter is 0 on the first BUS cycle, so the strobe
  // stays high for exactly TIMEOUT cycles.
  localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic {
    IDLE = 1'b0,
    BUS  = 1'b1
  } state_t;

  state_t          state_q;
  logic [LW-1:0]   last_q;
  logic [LW-1:0]   cur_q;
  logic [TW-1:0]   tmo_q;

  logic            pick_valid;
  logic [LW-1:0]   pick_idx;

  // Per-channel views of the packed client buses.
  logic [AW-1:0]   adr_a [NCH];
  logic [DW-1:0]   dat_a [NCH];
  logic [SW-1:0]   sel_a [NCH];

  for (genvar g = 0; g < NCH; g++) begin : g_unpack
    assign adr_a[g] = adr_i[g*AW +: AW];
    assign dat_a[g] = dat_i[g*DW +: DW];
    assign sel_a[g] = sel_i[g*SW +: SW];
  end

  // Round-robin search: the first requesting channel after the last granted one.
  always_comb begin
    logic [LW:0]   sum;
    logic [LW-1:0] cand;
    // NOTE: every variable written here gets a default first, so no path
    // through the block can leave a value held over, which would infer a latch.
    pick_valid = 1'b0;
    pick_idx   = '0;
    sum        = '0;
    cand       = '0;
    for (int i = 1; i <= NCH; i++) begin
      sum  = {1'b0, last_q} + (LW+1)'(i);
      if (sum >= (LW+1)'(NCH)) sum = sum - (LW+1)'(NCH);
      cand = sum[LW-1:0];
      if (!pick_valid && req_i[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Combinational grant: only in IDLE, and never while reset is held.
  always_comb begin
    gnt_o = '0;
    if (rst_i && (state_q == IDLE) && pick_valid) gnt_o = NCH'(1) << pick_idx;
  end

  // Transfer engine: arbitration, bus fields, timeout counter and completion.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      last_q   <= LW'(NCH - 1);
      cur_q    <= '0;
      tmo_q    <= '0;
      wb_adr_o <= '0;
      wb_dat_o <= '0;
      wb_sel_o <= '0;
      wb_we_o  <= 1'b0;
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      rdat_o   <= '0;
      done_o   <= '0;
      err_o    <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments only. Every
      // right-hand side therefore reads the pre-edge value, whatever the
      // statement order in this block.
      done_o <= '0;
      err_o  <= '0;
      unique case (state_q)
        IDLE: begin
          if (pick_valid) begin
            wb_adr_o <= adr_a[pick_idx];
            wb_dat_o <= dat_a[pick_idx];
            wb_sel_o <= sel_a[pick_idx];
            wb_we_o  <= we_i[pick_idx];
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            cur_q    <= pick_idx;
            last_q   <= pick_idx;
            tmo_q    <= '0;
            state_q  <= BUS;
          end
        end
        BUS: begin
          if (wb_err_i) begin
            // An err on the bus overrides a simultaneous ack.
            done_o   <= NCH'(1) << cur_q;
            err_o    <= NCH'(1) << cur_q;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            state_q  <= IDLE;
          end else if (wb_ack_i) begin
            done_o   <= NCH'(1) << cur_q;
            if (!wb_we_o) rdat_o <= wb_dat_i;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            state_q  <= IDLE;
          end else if ((TIMEOUT != 0) && (tmo_q == TO_LAST)) begin
            done_o   <= NCH'(1) << cur_q;
            err_o    <= NCH'(1) << cur_q;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            state_q  <= IDLE;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_moxie_wb_master.sv
// Directed bench for moxie_wb_master. The main instance is built with
// TIMEOUT=4 and driven by a scripted slave. A second instance is built with
// TIMEOUT=0 and faces a permanently silent slave.
module tb_moxie_wb_master;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int NCH = 2;
  localparam int SW  = DW / 8;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [NCH-1:0]    req_i, we_i;
  logic [NCH*AW-1:0] adr_i;
  logic [NCH*DW-1:0] dat_i;
  logic [NCH*SW-1:0] sel_i;
  logic [DW-1:0]     wb_dat_i;
  logic              wb_ack_i, wb_err_i;

  logic [NCH-1:0]    gnt_o, done_o, err_o;
  logic [DW-1:0]     rdat_o;
  logic [AW-1:0]     wb_adr_o;
  logic [DW-1:0]     wb_dat_o;
  logic [SW-1:0]     wb_sel_o;
  logic              wb_we_o, wb_cyc_o, wb_stb_o;

  // Signals of the timeout-disabled instance.
  logic [NCH-1:0]    req_nt;
  logic              ack_nt, err_nt;
  logic [NCH-1:0]    gnt_nt, done_nt, errf_nt;
  logic [DW-1:0]     rdat_nt;
  logic [AW-1:0]     adr_nt;
  logic [DW-1:0]     dat_nt;
  logic [SW-1:0]     sel_nt;
  logic              we_nt, cyc_nt, stb_nt;

  int cmp_cnt = 0;
  int err_cnt = 0;

  always #5 clk_i = ~clk_i;

  moxie_wb_master #(.AW(AW), .DW(DW), .NCH(NCH), .TIMEOUT(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_i(req_i), .we_i(we_i), .adr_i(adr_i), .dat_i(dat_i), .sel_i(sel_i),
    .gnt_o(gnt_o), .done_o(done_o), .err_o(err_o), .rdat_o(rdat_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
  );

  moxie_wb_master #(.AW(AW), .DW(DW), .NCH(NCH), .TIMEOUT(0)) dut_nt (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_i(req_nt), .we_i(we_i), .adr_i(adr_i), .dat_i(dat_i), .sel_i(sel_i),
    .gnt_o(gnt_nt), .done_o(done_nt), .err_o(errf_nt), .rdat_o(rdat_nt),
    .wb_adr_o(adr_nt), .wb_dat_o(dat_nt), .wb_sel_o(sel_nt),
    .wb_we_o(we_nt), .wb_cyc_o(cyc_nt), .wb_stb_o(stb_nt),
    .wb_dat_i(wb_dat_i), .wb_ack_i(ack_nt), .wb_err_i(err_nt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock. Drives and checks happen 2 time units after the edge.
  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  initial begin
    rst_i    = 1'b0;
    req_i    = '0;
    we_i     = '0;
    adr_i    = '0;
    dat_i    = '0;
    sel_i    = '0;
    wb_dat_i = '0;
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    req_nt   = '0;
    ack_nt   = 1'b0;
    err_nt   = 1'b0;

    // ---- reset held with random inputs: every output stays 0
    for (int i = 0; i < 4; i++) begin
      req_i    = NCH'($urandom);
      we_i     = NCH'($urandom);
      adr_i    = {$urandom, $urandom};
      dat_i    = {$urandom, $urandom};
      sel_i    = SW*NCH'($urandom);
      wb_dat_i = $urandom;
      wb_ack_i = 1'($urandom);
      wb_err_i = 1'($urandom);
      req_nt   = NCH'($urandom);
      step();
      check("rst_gnt", 64'(gnt_o), 64'h0);
      check("rst_bus", {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o}, 64'h0);
      check("rst_adr_dat", {wb_adr_o, wb_dat_o}, 64'h0);
      check("rst_rdat_done", {rdat_o, done_o, err_o}, 64'h0);
      check("rst_nt_stb", 64'(stb_nt), 64'h0);
    end
    req_i = '0; we_i = '0; adr_i = '0; dat_i = '0; sel_i = '0;
    wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_dat_i = '0; req_nt = '0;

    // ---- release, ch0 first priority, zero-wait read
    rst_i = 1'b1;
    req_i = 2'b01;
    adr_i[0*AW +: AW] = 32'h0000_0040;
    sel_i[0*SW +: SW] = 4'hF;
    #1 check("first_gnt", 64'(gnt_o), 64'h1);
    step();
    req_i = '0;
    check("first_stb", {wb_cyc_o, wb_stb_o}, 64'h3);
    check("first_adr", 64'(wb_adr_o), 64'h40);
    check("first_gnt_bus", 64'(gnt_o), 64'h0);
    wb_ack_i = 1'b1;
    wb_dat_i = 32'h0000_5555;
    step();
    wb_ack_i = 1'b0;
    check("first_done", {done_o, err_o}, 64'h4);
    check("first_stb_low", 64'(wb_stb_o), 64'h0);
    check("first_rdat", 64'(rdat_o), 64'h5555);

    // ---- ch1 read of 0x100, ack on the third strobe cycle
    req_i = 2'b10;
    we_i  = 2'b00;
    adr_i[1*AW +: AW] = 32'h0000_0100;
    sel_i[1*SW +: SW] = 4'hF;
    #1 check("rd_gnt", 64'(gnt_o), 64'h2);
    step();
    req_i = '0;
    for (int k = 0; k < 3; k++) begin
      check("rd_hold", {wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o}, {26'h0, 1'b1, 1'b0, 4'hF, 32'h100});
      if (k == 2) begin
        wb_ack_i = 1'b1;
        wb_dat_i = 32'hDEAD_BEEF;
      end
      step();
    end
    wb_ack_i = 1'b0;
    check("rd_done", {done_o, err_o}, 64'h8);
    check("rd_rdat", 64'(rdat_o), 64'hDEAD_BEEF);
    check("rd_stb_low", 64'(wb_stb_o), 64'h0);

    // ---- round-robin with both channels requesting and zero-wait acks
    req_i    = 2'b11;
    wb_ack_i = 1'b1;
    wb_dat_i = 32'hCAFE_F00D;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("rr_gnt", 64'(gnt_o), (k % 2 == 0) ? 64'h1 : 64'h2);
      check("rr_idle_stb", 64'(wb_stb_o), 64'h0);
      step();
      check("rr_bus", {gnt_o, wb_stb_o}, 64'h1);
      step();
      check("rr_done", 64'(done_o), (k % 2 == 0) ? 64'h1 : 64'h2);
    end
    req_i    = '0;
    wb_ack_i = 1'b0;
    check("rr_rdat", 64'(rdat_o), 64'hCAFE_F00D);

    // ---- ch0 write, rdat must keep its earlier value
    req_i = 2'b01;
    we_i  = 2'b01;
    dat_i[0*DW +: DW] = 32'h1234_5678;
    sel_i[0*SW +: SW] = 4'h3;
    #1 check("wr_gnt", 64'(gnt_o), 64'h1);
    step();
    req_i = '0;
    check("wr_fields", {wb_we_o, wb_sel_o, wb_dat_o}, {27'h0, 1'b1, 4'h3, 32'h1234_5678});
    wb_ack_i = 1'b1;
    wb_dat_i = 32'h1111_1111;
    step();
    wb_ack_i = 1'b0;
    we_i     = '0;
    check("wr_done", {done_o, err_o}, 64'h4);
    check("wr_rdat_kept", 64'(rdat_o), 64'hCAFE_F00D);

    // ---- err together with ack: err wins, rdat unchanged
    req_i = 2'b10;
    #1 check("err_gnt", 64'(gnt_o), 64'h2);
    step();
    req_i    = '0;
    wb_ack_i = 1'b1;
    wb_err_i = 1'b1;
    wb_dat_i = 32'h2222_2222;
    step();
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    check("err_done", {done_o, err_o}, 64'hA);
    check("err_rdat_kept", 64'(rdat_o), 64'hCAFE_F00D);

    // ---- timeout with a silent slave: strobe high exactly 4 cycles
    req_i = 2'b01;
    #1 check("to_gnt", 64'(gnt_o), 64'h1);
    step();
    req_i = '0;
    for (int k = 0; k < 4; k++) begin
      check("to_stb_high", {wb_stb_o, done_o}, 64'h4);
      step();
    end
    check("to_done", {done_o, err_o}, 64'h5);
    check("to_stb_low", {wb_cyc_o, wb_stb_o}, 64'h0);

    // ---- reset in the middle of a transfer
    req_i = 2'b10;
    step();
    req_i = '0;
    check("mid_stb", 64'(wb_stb_o), 64'h1);
    #1 rst_i = 1'b0;
    #1 check("mid_async_drop", {wb_cyc_o, wb_stb_o}, 64'h0);
    step();
    check("mid_no_done", {done_o, err_o}, 64'h0);
    rst_i = 1'b1;
    req_i = 2'b11;
    #1 check("mid_prio", 64'(gnt_o), 64'h1);
    step();
    req_i    = '0;
    wb_ack_i = 1'b1;
    step();
    wb_ack_i = 1'b0;
    check("mid_done", {done_o, err_o}, 64'h4);

    // ---- timeout disabled: the strobe never drops on a silent slave
    req_nt = 2'b01;
    #1 check("nt_gnt", 64'(gnt_nt), 64'h1);
    step();
    req_nt = '0;
    check("nt_stb", 64'(stb_nt), 64'h1);
    repeat (300) step();
    check("nt_stb_still", {cyc_nt, stb_nt, done_nt, errf_nt}, 64'h30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
